// File: rtl/sha_probe_pkg.sv
// ---------------------------------------------------------------------------
// sha_probe_pkg
// Shared definitions for the SHA core latency probe:
//   - SHA_PROBE_CNT_W : default timestamp / latency width
//   - probe_state_e   : measurement FSM states (IDLE, RUN)
//   - probe_result_t  : one buffered result {sat, lat} at the default width
// Modules built with a non-default CNT_W pack the same {sat, lat} layout at
// their own width.
// ---------------------------------------------------------------------------
package sha_probe_pkg;

   localparam int SHA_PROBE_CNT_W = 30;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } probe_state_e;

   typedef struct packed {
      logic                       sat;
      logic [SHA_PROBE_CNT_W-1:0] lat;
   } probe_result_t;

endpackage

// File: rtl/probe_fifo.sv
// ---------------------------------------------------------------------------
// probe_fifo
// Synchronous first-word-fall-through FIFO.  The head entry is visible on
// pop_data in the cycle after it is pushed.  A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is
// dropped (the caller detects this via full).
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data this cycle
//   push_data  : entry to write (WIDTH bits)
//   pop        : remove the head entry (ignored when empty)
//   pop_data   : head entry, valid while empty is low
//   full/empty : occupancy status
// Parameters: WIDTH (entry width), DEPTH (power of two, 2..16)
// ---------------------------------------------------------------------------
module probe_fifo #(
   parameter int WIDTH = 31,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign full     = (cnt_q == (AW+1)'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign pop_data = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so a full FIFO can still take a
   // push when it is being popped.  Pointers wrap naturally (DEPTH is 2^n).
   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: reads are only meaningful while not empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/sha_latency_probe.sv
// ---------------------------------------------------------------------------
// sha_latency_probe
// Measures hash-core latency between a start pulse and a done pulse using an
// external free-running saturating cycle count, and buffers {sat, latency}
// results in a small FWFT FIFO for a ready/valid consumer.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   count        : upstream saturating cycle count (CNT_W bits)
//   start, done  : one-cycle pulses from the hash core
//   out_valid    : FIFO head holds a result
//   out_ready    : consumer accepts the head
//   out_latency  : head latency (0 when out_valid is low)
//   out_sat      : head latency unreliable (counter saturated / went back)
//   busy         : measurement in progress
//   overflow     : sticky, a result was dropped on a full FIFO
//   proto_err    : sticky, start seen while already measuring
//   min_lat      : running minimum of non-sat pushed latencies
//   max_lat      : running maximum of non-sat pushed latencies
// Parameters: CNT_W (default 30), FIFO_DEPTH (power of two, 2..16)
// Optional feature: define SHA_PROBE_MINMAX_EN to build the min/max
// trackers; without it min_lat and max_lat are tied to 0.
// ---------------------------------------------------------------------------
module sha_latency_probe
   import sha_probe_pkg::*;
#(
   parameter int CNT_W      = SHA_PROBE_CNT_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] count,
   input  logic             start,
   input  logic             done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_latency,
   output logic             out_sat,
   output logic             busy,
   output logic             overflow,
   output logic             proto_err,
   output logic [CNT_W-1:0] min_lat,
   output logic [CNT_W-1:0] max_lat
);

   typedef struct packed {
      logic             sat;
      logic [CNT_W-1:0] lat;
   } result_t;

   probe_state_e     state_q, state_d;
   logic [CNT_W-1:0] t0_q, t0_d;
   logic             overflow_q, overflow_d;
   logic             proto_err_q, proto_err_d;

   logic             push_req;
   result_t          push_res;
   result_t          head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;

   assign busy      = (state_q == ST_RUN);
   assign overflow  = overflow_q;
   assign proto_err = proto_err_q;
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;

   // The head is masked to zero while nothing is buffered so the consumer
   // never sees stale storage contents.
   assign out_latency = out_valid ? head.lat : '0;
   assign out_sat     = out_valid ? head.sat : 1'b0;

   // Latency is a modular difference; it is flagged unreliable if the
   // counter has saturated or appears to have moved backwards.
   always_comb begin
      push_res.lat = count - t0_q;
      push_res.sat = (&count) || (count < t0_q);
   end

   // Measurement FSM.  In RUN a done closes the current measurement; a start
   // in the same cycle immediately opens the next one.  A lone start in RUN
   // is a protocol error and keeps the original timestamp.  In IDLE done is
   // ignored, even when it coincides with start.
   always_comb begin
      state_d     = state_q;
      t0_d        = t0_q;
      proto_err_d = proto_err_q;
      push_req    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               t0_d    = count;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (done) begin
               push_req = 1'b1;
               if (start) begin
                  t0_d = count;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (start) begin
               proto_err_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // A push is lost only when the FIFO is full and no pop frees a slot.
   always_comb begin
      overflow_d = overflow_q;
      if (push_req && fifo_full && !pop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         t0_q        <= '0;
         overflow_q  <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         t0_q        <= t0_d;
         overflow_q  <= overflow_d;
         proto_err_q <= proto_err_d;
      end
   end

   probe_fifo #(
      .WIDTH (CNT_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_req),
      .push_data (push_res),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef SHA_PROBE_MINMAX_EN
   logic [CNT_W-1:0] min_lat_q, min_lat_d;
   logic [CNT_W-1:0] max_lat_q, max_lat_d;

   // Statistics follow every reliable result the probe produced, including
   // ones the FIFO had to drop.
   always_comb begin
      min_lat_d = min_lat_q;
      max_lat_d = max_lat_q;
      if (push_req && !push_res.sat) begin
         if (push_res.lat < min_lat_q) begin
            min_lat_d = push_res.lat;
         end
         if (push_res.lat > max_lat_q) begin
            max_lat_d = push_res.lat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         min_lat_q <= '1;
         max_lat_q <= '0;
      end else begin
         min_lat_q <= min_lat_d;
         max_lat_q <= max_lat_d;
      end
   end

   assign min_lat = min_lat_q;
   assign max_lat = max_lat_q;
`else
   assign min_lat = '0;
   assign max_lat = '0;
`endif

endmodule

// File: doc/sha_latency_probe.md
SHA_LATENCY_PROBE -- requirements
Module: sha_latency_probe

Interface
REQ-001 SHALL have parameter CNT_W, default 30, timestamp/latency width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of result entries buffered; power of two, range 2..16.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-005 SHALL have port count  input  CNT_W  free-running saturating cycle count from the upstream counter.
REQ-006 SHALL have port start  input  1  one-cycle pulse marking hash-core start.
REQ-007 SHALL have port done  input  1  one-cycle pulse marking hash-core completion.
REQ-008 SHALL have port out_valid  output  1  FIFO head holds a result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts head when high with out_valid.
REQ-010 SHALL have port out_latency  output  CNT_W  head latency in cycles.
REQ-011 SHALL have port out_sat  output  1  head latency is unreliable: counter saturated or went backwards.
REQ-012 SHALL have port busy  output  1  measurement in progress.
REQ-013 SHALL have port overflow  output  1  sticky: result dropped because FIFO full.
REQ-014 SHALL have port proto_err  output  1  sticky: start received while busy.
REQ-015 SHALL have ports min_lat, max_lat  output  CNT_W  running min/max of pushed, non-sat latencies.

Function
REQ-016 SHALL implement FSM with states IDLE and RUN; busy = (state == RUN).
REQ-017 IDLE + start: SHALL latch t0 = count and go to RUN next cycle.
REQ-018 IDLE + done: SHALL ignore done; no push, no flag.
REQ-019 RUN + done (no start): SHALL compute lat = count - t0 modulo 2^CNT_W, push {sat, lat}, return to IDLE.
REQ-020 sat SHALL be 1 when count == all-ones at done or count < t0; otherwise 0.
REQ-021 RUN + start + done same cycle: SHALL push result for the closing measurement and latch t0 = count, staying in RUN.
REQ-022 RUN + start without done: SHALL keep the original t0 and set proto_err.
REQ-023 IDLE + start + done same cycle: SHALL take start and ignore done.
REQ-024 Result pushed on done cycle N SHALL appear on out_valid/out_latency in cycle N+1 (first-word-fall-through).
REQ-025 Pop SHALL occur only when out_valid && out_ready; out_latency/out_sat SHALL hold stable while out_valid && !out_ready.
REQ-026 Push to a full FIFO SHALL drop the new result and set overflow; a pop and push in the same cycle on a full FIFO SHALL both succeed.
REQ-027 Pop on empty SHALL have no effect; out_latency SHALL read 0 when out_valid is 0.

Reset
REQ-028 rst SHALL force state IDLE, t0 0, FIFO empty, out_valid 0, out_latency 0, out_sat 0, busy 0, overflow 0, proto_err 0.
REQ-029 rst SHALL force min_lat to all-ones and max_lat to 0.
REQ-030 rst asserted during RUN SHALL abandon the measurement without a push; rst has priority over start and done.

Configuration
REQ-031 Macro SHA_PROBE_MINMAX_EN defined: min_lat/max_lat SHALL update on each push with sat=0, including pushes dropped on overflow.
REQ-032 Macro SHA_PROBE_MINMAX_EN undefined: min/max registers SHALL be absent, and min_lat and max_lat SHALL be driven constant 0.

Structure
REQ-033 Shared package sha_probe_pkg SHALL hold CNT_W default constant, FSM state enum, and a result struct typedef {sat, lat}.
REQ-034 Buffering SHALL be a separate sub-module probe_fifo (synchronous FWFT FIFO, parameter DEPTH, full/empty outputs).

Verification
REQ-035 start at count=100, done at count=164, out_ready=1 -> next cycle out_valid=1, out_latency=64, out_sat=0.
REQ-036 out_ready=0, five measurements of 10 cycles each, FIFO_DEPTH=4 -> four entries of latency 10 retained, overflow=1.
REQ-037 start at t0=5, start again at count=9, done at count=20 -> latency 15, proto_err=1.
REQ-038 start+done same cycle at counts 50 then 80 (after start at 20) -> latencies 30 and 30 pushed, busy stays 1.
REQ-039 start at count=2^30-10, count held at 2^30-1, done -> out_sat=1; with SHA_PROBE_MINMAX_EN, min/max unchanged.
REQ-040 rst mid-RUN then done -> no push, out_valid=0, busy=0, all sticky flags 0.
